// File: rtl/uart_pkg.sv
// Shared constants for the UART CPU bus bridge: register map, STATUS/CTRL
// bit positions and the default baud divisor.
package uart_pkg;

    // Register addresses
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DVSR_LO = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS bit indices
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_DROP  = 2;
    localparam int ST_RX_UNDER = 3;
    localparam int ST_IRQ      = 7;

    // CTRL bit indices (bits [2:0] carry dvsr[10:8])
    localparam int CTRL_RX_IE = 6;
    localparam int CTRL_TX_IE = 7;

    // Divisor width and default (115,200 baud at 50 MHz)
    localparam int DVSR_W       = 11;
    localparam int DVSR_DEFAULT = 26;

endpackage

// File: rtl/uart_access_strobe.sv
// Chip-select rising-edge detector. The history flop resets to 1 so that a
// chip select already asserted when reset releases is not seen as an access.
module uart_access_strobe (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    output logic acc
);

    logic cs_q;
    logic cs_d;

    // Next history value is simply the current chip select
    always_comb begin
        cs_d = cs;
    end

    // History register, reset high to suppress an in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q <= 1'b1;
        end else begin
            cs_q <= cs_d;
        end
    end

    assign acc = cs & ~cs_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// CPU register bridge in front of the UART FIFOs: turns chip-select accesses
// into single-cycle push/pop strobes, holds sticky error flags and the baud
// divisor. Optional interrupt logic is enabled by defining UART_IRQ_EN.
module uart_bus_bridge
    import uart_pkg::*;
#(
    parameter int DVSR_RESET = DVSR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              irq,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    input  logic              tx_full,
    output logic              rd_uart,
    input  logic [7:0]        r_data,
    input  logic              rx_empty,
    output logic [DVSR_W-1:0] dvsr
);

    logic              acc;
    logic [7:0]        dout_q,     dout_d;
    logic              irq_q,      irq_d;
    logic              wr_uart_q,  wr_uart_d;
    logic [7:0]        w_data_q,   w_data_d;
    logic              rd_uart_q,  rd_uart_d;
    logic [DVSR_W-1:0] dvsr_q,     dvsr_d;
    logic              tx_drop_q,  tx_drop_d;
    logic              rx_under_q, rx_under_d;
    logic              rx_ie_q,    rx_ie_d;
    logic              tx_ie_q,    tx_ie_d;
    logic              tx_drop_set;
    logic              rx_under_set;
    logic [7:0]        status_val;
    logic [7:0]        ctrl_val;

    uart_access_strobe u_strobe (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .acc   (acc)
    );

    // Read-back images of STATUS and CTRL; reserved bits read as zero
    always_comb begin
        status_val                 = 8'h00;
        status_val[ST_RX_AVAIL]    = ~rx_empty;
        status_val[ST_TX_FULL]     = tx_full;
        status_val[ST_TX_DROP]     = tx_drop_q;
        status_val[ST_RX_UNDER]    = rx_under_q;
        status_val[ST_IRQ]         = irq_q;
        ctrl_val                   = 8'h00;
        ctrl_val[2:0]              = dvsr_q[10:8];
        ctrl_val[CTRL_RX_IE]       = rx_ie_q;
        ctrl_val[CTRL_TX_IE]       = tx_ie_q;
    end

    // Register access decode: one action per chip-select rising edge
    always_comb begin
        dout_d       = dout_q;
        wr_uart_d    = 1'b0;
        w_data_d     = w_data_q;
        rd_uart_d    = 1'b0;
        dvsr_d       = dvsr_q;
        tx_drop_d    = tx_drop_q;
        rx_under_d   = rx_under_q;
        rx_ie_d      = rx_ie_q;
        tx_ie_d      = tx_ie_q;
        tx_drop_set  = 1'b0;
        rx_under_set = 1'b0;
        if (acc) begin
            if (we) begin
                case (addr)
                    REG_DATA: begin
                        if (!tx_full) begin
                            wr_uart_d = 1'b1;
                            w_data_d  = din;
                        end else begin
                            tx_drop_set = 1'b1;
                        end
                    end
                    REG_STATUS: begin
                        if (din[ST_TX_DROP])  tx_drop_d  = 1'b0;
                        if (din[ST_RX_UNDER]) rx_under_d = 1'b0;
                    end
                    REG_DVSR_LO: dvsr_d[7:0] = din;
                    REG_CTRL: begin
                        dvsr_d[10:8] = din[2:0];
`ifdef UART_IRQ_EN
                        rx_ie_d = din[CTRL_RX_IE];
                        tx_ie_d = din[CTRL_TX_IE];
`endif
                    end
                    default: ;
                endcase
            end else begin
                case (addr)
                    REG_DATA: begin
                        if (!rx_empty) begin
                            dout_d    = r_data;
                            rd_uart_d = 1'b1;
                        end else begin
                            dout_d       = 8'h00;
                            rx_under_set = 1'b1;
                        end
                    end
                    REG_STATUS:  dout_d = status_val;
                    REG_DVSR_LO: dout_d = dvsr_q[7:0];
                    REG_CTRL:    dout_d = ctrl_val;
                    default: ;
                endcase
            end
        end
        // A set event in the same cycle as a W1C clear keeps the flag set
        if (tx_drop_set)  tx_drop_d  = 1'b1;
        if (rx_under_set) rx_under_d = 1'b1;
    end

    // Interrupt request: level sources gated by enables plus the stickies
    always_comb begin
`ifdef UART_IRQ_EN
        irq_d = (rx_ie_q & ~rx_empty) | (tx_ie_q & ~tx_full) | tx_drop_q | rx_under_q;
`else
        irq_d = 1'b0;
`endif
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q     <= 8'h00;
            irq_q      <= 1'b0;
            wr_uart_q  <= 1'b0;
            w_data_q   <= 8'h00;
            rd_uart_q  <= 1'b0;
            dvsr_q     <= DVSR_W'(DVSR_RESET);
            tx_drop_q  <= 1'b0;
            rx_under_q <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            irq_q      <= irq_d;
            wr_uart_q  <= wr_uart_d;
            w_data_q   <= w_data_d;
            rd_uart_q  <= rd_uart_d;
            dvsr_q     <= dvsr_d;
            tx_drop_q  <= tx_drop_d;
            rx_under_q <= rx_under_d;
            rx_ie_q    <= rx_ie_d;
            tx_ie_q    <= tx_ie_d;
        end
    end

    assign dout    = dout_q;
    assign irq     = irq_q;
    assign wr_uart = wr_uart_q;
    assign w_data  = w_data_q;
    assign rd_uart = rd_uart_q;
    assign dvsr    = dvsr_q;

endmodule
